// File: rtl/axi4_master_bridge.sv
// AXI4 master bridge: single-outstanding CPU request port to AXI4 INCR read bursts and
// single-beat writes. Read beats and write responses return through a one-entry response slot.
module axi4_master_bridge #(
    parameter logic [3:0] ID_VAL  = 4'h0,
    parameter logic [7:0] MAX_LEN = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [7:0]  req_len,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_last,
    output logic        resp_err,

    output logic        io_master_awvalid,
    input  logic        io_master_awready,
    output logic [31:0] io_master_awaddr,
    output logic [3:0]  io_master_awid,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,

    output logic        io_master_wvalid,
    input  logic        io_master_wready,
    output logic [31:0] io_master_wdata,
    output logic [3:0]  io_master_wstrb,
    output logic        io_master_wlast,

    output logic        io_master_bready,
    input  logic        io_master_bvalid,
    input  logic [1:0]  io_master_bresp,
    input  logic [3:0]  io_master_bid,

    output logic        io_master_arvalid,
    input  logic        io_master_arready,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,

    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [31:0] io_master_rdata,
    input  logic [1:0]  io_master_rresp,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_last_q, resp_last_d;
    logic        resp_err_q, resp_err_d;
    logic        slot_free;
    logic        aw_fire, w_fire;
    logic        unused_ids;

    // Single outstanding transaction, so returned IDs carry no information.
    assign unused_ids = ^{io_master_rid, io_master_bid};

    assign slot_free = !resp_valid_q || resp_ready;

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_last  = resp_last_q;
    assign resp_err   = resp_err_q;

    assign io_master_awaddr  = addr_q;
    assign io_master_awid    = ID_VAL;
    assign io_master_awlen   = 8'h00;
    assign io_master_awsize  = 3'b010;
    assign io_master_awburst = 2'b01;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = 1'b1;
    assign io_master_araddr  = addr_q;
    assign io_master_arid    = ID_VAL;
    assign io_master_arlen   = len_q;
    assign io_master_arsize  = 3'b010;
    assign io_master_arburst = 2'b01;

    always_comb begin
        io_master_arvalid = 1'b0;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_rready  = 1'b0;
        io_master_bready  = 1'b0;
        aw_fire           = 1'b0;
        w_fire            = 1'b0;
        state_d           = state_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        wstrb_d           = wstrb_q;
        len_d             = len_q;
        beat_d            = beat_q;
        aw_done_d         = aw_done_q;
        w_done_d          = w_done_q;
        resp_valid_d      = resp_valid_q;
        resp_data_d       = resp_data_q;
        resp_last_d       = resp_last_q;
        resp_err_d        = resp_err_q;

        // A new beat loading in the same cycle overrides this clear below.
        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    len_d     = (req_len > MAX_LEN) ? MAX_LEN : req_len;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_wen ? WADDR : RADDR;
                end
            end
            RADDR: begin
                io_master_arvalid = 1'b1;
                if (io_master_arready) begin
                    beat_d  = len_q;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                io_master_rready = slot_free;
                if (io_master_rvalid && slot_free) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = io_master_rdata;
                    resp_last_d  = (beat_q == 8'h00);
                    resp_err_d   = (io_master_rresp != 2'b00) ||
                                   (io_master_rlast != (beat_q == 8'h00));
                    if (beat_q == 8'h00) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q - 8'h01;
                    end
                end
            end
            WADDR: begin
                io_master_awvalid = !aw_done_q;
                io_master_wvalid  = !w_done_q;
                aw_fire           = !aw_done_q && io_master_awready;
                w_fire            = !w_done_q && io_master_wready;
                if (aw_fire) aw_done_d = 1'b1;
                if (w_fire)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                io_master_bready = slot_free;
                if (io_master_bvalid && slot_free) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                    resp_last_d  = 1'b1;
                    resp_err_d   = (io_master_bresp != 2'b00);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered so that req_ready reads 0 during reset like every other handshake output.
        req_ready_d = (state_d == IDLE) && !resp_valid_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_last_q  <= resp_last_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule
